// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host master: FSM state encoding,
// default watchdog limit and the byte-select width helper.
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_host_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wb_host_master_if.sv
// Request/response channel plus Wishbone master signals of wb_host_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface wb_host_master_if
  import wb_host_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = sel_width(DATA_W)
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_adr_i;
    logic [DATA_W-1:0] req_dat_i;
    logic [SEL_W-1:0]  req_sel_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_dat_o;
    logic              rsp_err_o;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output req_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_host_watchdog.sv
// Saturating strobe-cycle counter; expired_o flags the last strobe cycle allowed
// before the master must abort.
module wb_host_watchdog #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired_o
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Combinational look-ahead so the abort lands on the edge that ends strobe cycle `limit`.
    assign expired_o = enable && (count >= limit - CNT_W'(1));

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master: one request becomes one cyc/stb cycle,
// with an optional watchdog that turns a missing ack into an error response.
module wb_host_master
  import wb_host_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_host_master_if.master  bus,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUS  = BUS;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0] state;
    logic       accept;
    logic       expired;

    assign bus.req_ready_o = (state == S_IDLE) && !wb_rst_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    generate
        if (TIMEOUT != 0) begin : g_watchdog
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
            wb_host_watchdog #(.CNT_W(CNT_W)) u_watchdog (
                .clk       (wb_clk_i),
                .rst       (wb_rst_i),
                .clear     (accept),
                .enable    (state == S_BUS),
                .limit     (CNT_W'(TIMEOUT)),
                .expired_o (expired)
            );
        end else begin : g_no_watchdog
            assign expired = 1'b0;
        end
    endgenerate

    // NOTE: every register below uses <= so all state updates see pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= S_IDLE;
            busy_o          <= 1'b0;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.wbm_adr_o   <= '0;
            bus.wbm_dat_o   <= '0;
            bus.wbm_sel_o   <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_dat_o   <= '0;
            bus.rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state         <= S_BUS;
                        busy_o        <= 1'b1;
                        bus.wbm_cyc_o <= 1'b1;
                        bus.wbm_stb_o <= 1'b1;
                        bus.wbm_we_o  <= bus.req_we_i;
                        bus.wbm_adr_o <= bus.req_adr_i;
                        bus.wbm_dat_o <= bus.req_dat_i;
                        bus.wbm_sel_o <= bus.req_sel_i;
                    end
                end
                S_BUS: begin
                    // Ack has priority over a watchdog expiry in the same cycle.
                    if (bus.wbm_ack_i) begin
                        state           <= S_RESP;
                        bus.wbm_cyc_o   <= 1'b0;
                        bus.wbm_stb_o   <= 1'b0;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_dat_o   <= bus.wbm_we_o ? '0 : bus.wbm_dat_i;
                        bus.rsp_err_o   <= 1'b0;
                    end else if (expired) begin
                        state           <= S_RESP;
                        bus.wbm_cyc_o   <= 1'b0;
                        bus.wbm_stb_o   <= 1'b0;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_dat_o   <= '0;
                        bus.rsp_err_o   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state           <= S_IDLE;
                        busy_o          <= 1'b0;
                        bus.rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
